pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Parametrised hazard controller for the five-stage MIPS pipeline. It tracks the destination registers of in-flight instructions in an internal scoreboard. From these it generates the per-latch enable and synchronous-clear pairs, the PC enable and registered operand-forwarding selects. It also runs a data-memory wait state machine with a consecutive-stall watchdog. It sits beside the datapath between the IF/ID, ID/EX, EX/MEM and MEM/WB latches.

## Interface
- REG_AW, 5, register-select width.
- SB_DEPTH, 3, scoreboard entries past decode (3..6). Entries 0/1/2 mirror ID/EX, EX/MEM, MEM/WB.
- STALL_W, 8, watchdog counter width.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- id_valid, id_wen, id_load  in  1 each  decode-stage instruction valid, writes a register, is a load.
- id_rsel1, id_rsel2, id_wsel  in  REG_AW each  decode-stage source and destination selects.
- ex_branch_taken  in  1  taken branch or jump resolved in EX.
- ihit  in  1  instruction fetch complete.
- dmemREN, dmemWEN, dhit  in  1 each  MEM-stage data request and completion.
- pc_en  out  1  PC update enable.
- ifid_en, ifid_sRST, idex_en, idex_sRST, exmem_en, exmem_sRST, memwb_en, memwb_sRST  out  1 each  latch hold (en=0) and bubble insert (sRST=1).
- fwd_a, fwd_b  out  2 each  registered EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB.
- rambusy  out  1  arbitration hint: data side owns memory.
- stall_cnt  out  STALL_W  consecutive stall cycles, saturating.
- stall_timeout  out  1  stall_cnt at all-ones.

## Operation
- Scoreboard entry fields: {v, wsel, load}. A decode instruction enters with v = id_valid & id_wen & (id_wsel != 0).
- Entry 0 loads on idex_en. It loads invalid if idex_sRST is set.
- Entry 1 loads entry 0 on exmem_en. It loads invalid if exmem_sRST is set.
- Entry 2 loads entry 1 on memwb_en. It loads invalid if memwb_sRST is set.
- Entries 3 and above shift every cycle.
- Match(k): entry k valid and its wsel equals a nonzero id_rsel1 or id_rsel2, with id_valid set.
- The last entry never produces a hazard. The regfile is write-first.
- FSM states: RUN and DWAIT.
  - RUN goes to DWAIT on (dmemREN|dmemWEN) & !dhit.
  - DWAIT goes to RUN on dhit.
  - DWAIT stays in DWAIT while the request is held.
  - If the request drops in DWAIT, go to RUN.
- Control priority, highest first:
  1. Memory wait, (dmemREN|dmemWEN) & !dhit in either state. Set pc_en, ifid_en, idex_en and exmem_en to 0. Set memwb_sRST to 1.
  2. Branch flush, ex_branch_taken. Set ifid_sRST and idex_sRST to 1. All enables are 1.
  3. RAW stall. Set pc_en and ifid_en to 0. Set idex_sRST to 1.
  4. Fetch miss, !ihit. Set pc_en to 0. Set ifid_sRST to 1.
  5. Otherwise all enables are 1 and all sRST are 0.
- rambusy = (dmemREN|dmemWEN) & !dhit.
- fwd_a and fwd_b are computed at decode and register when idex_en=1. They clear to 0 when idex_sRST=1.
  - Select 1 if entry 0 matches.
  - Otherwise select 2 if entry 1 matches.
  - Otherwise select 0.
  - The youngest producer wins.
- stall_cnt increments each cycle pc_en=0, saturating at all-ones. It clears on any cycle with pc_en=1.

## Timing
- Reset values:
  - Scoreboard all invalid, state RUN, fwd_a and fwd_b 0, stall_cnt 0, stall_timeout 0.
  - With idle inputs (ihit=1): all enables 1, all sRST 0, pc_en 1, rambusy 0.
- Latch controls and rambusy are combinational, same cycle as their inputs.
- fwd_a, fwd_b, scoreboard and stall_cnt update on the CLK edge.
- A dhit in the request cycle causes no stall and no DWAIT entry.
- A branch flush coinciding with a RAW stall: flush wins. The stalled consumer is discarded.
- nRST asserted mid-DWAIT returns the block to RUN and clears the scoreboard immediately.

## Configuration
- FORWARDING_EN defined:
  - RAW stall only when entry 0 matches and entry 0 is a load. This is exactly one bubble.
  - Forwarding covers all other cases.
- FORWARDING_EN undefined:
  - fwd_a and fwd_b are tied to 0.
  - RAW stall on a match in any entry 0..SB_DEPTH-2.

## Test plan
- Reset, then idle with ihit=1 → all enables 1, sRST 0, fwd 0, stall_cnt 0.
- add $3 followed by sub $4,$3,$5 with FORWARDING_EN → no stall, fwd_a=1 registered. Without the macro → 2 stall cycles (SB_DEPTH=3), idex_sRST=1 each cycle.
- lw $2 followed by addi $6,$2 with FORWARDING_EN → exactly 1 bubble, then fwd_a=2.
- dmemREN=1 with dhit low for 4 cycles → DWAIT for 4 cycles, memwb_sRST=1 throughout, stall_cnt reaches 4, then RUN on dhit.
- ex_branch_taken together with a RAW match → ifid_sRST=1 and idex_sRST=1, ifid_en=1, pc_en=1.
- Request held 255 cycles with STALL_W=8 → stall_timeout=1 and stall_cnt holds at 255. nRST pulse → RUN, counter 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard control for the five-stage MIPS pipeline. A scoreboard of in-flight
// destination registers drives the latch enable/clear pairs, the PC enable
// and the registered EX operand-forwarding selects. It also holds the
// data-memory wait FSM and a consecutive-stall watchdog.
// Optional build macro: FORWARDING_EN. When it is defined, only a load-use
// hazard stalls and the EX/MEM and MEM/WB results are forwarded. When it is
// undefined, the forward selects are tied to 0 and any scoreboard match stalls.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int SB_DEPTH = 3,
  parameter int STALL_W  = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               id_valid,
  input  logic               id_wen,
  input  logic               id_load,
  input  logic [REG_AW-1:0]  id_rsel1,
  input  logic [REG_AW-1:0]  id_rsel2,
  input  logic [REG_AW-1:0]  id_wsel,
  input  logic               ex_branch_taken,
  input  logic               ihit,
  input  logic               dmemREN,
  input  logic               dmemWEN,
  input  logic               dhit,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_sRST,
  output logic               idex_en,
  output logic               idex_sRST,
  output logic               exmem_en,
  output logic               exmem_sRST,
  output logic               memwb_en,
  output logic               memwb_sRST,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               rambusy,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               stall_timeout
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] wsel;
    logic              load;
  } sb_ent_t;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DWAIT = 1'b1;

  sb_ent_t             sb [SB_DEPTH];
  sb_ent_t             id_ent;
  logic [SB_DEPTH-2:0] m1, m2;
  logic                mem_req, mem_wait, raw_hit;
  logic [0:0]          state, state_nxt;

  assign mem_req  = dmemREN | dmemWEN;
  assign mem_wait = mem_req & ~dhit;
  assign rambusy  = mem_wait;

  // $0 is never a real destination, so it never enters as valid.
  assign id_ent = {id_valid & id_wen & (id_wsel != '0), id_wsel, id_load};

  // The oldest entry is written back before decode reads (write-first
  // regfile), so it is left out of the match vector.
  for (genvar k = 0; k < SB_DEPTH-1; k++) begin : g_match
    assign m1[k] = id_valid && sb[k].v && (id_rsel1 != '0) && (sb[k].wsel == id_rsel1);
    assign m2[k] = id_valid && sb[k].v && (id_rsel2 != '0) && (sb[k].wsel == id_rsel2);
  end

`ifdef FORWARDING_EN
  // Only a load in ID/EX cannot be forwarded in time: one bubble.
  assign raw_hit = (m1[0] | m2[0]) & sb[0].load;
`else
  assign raw_hit = |{m1, m2};
`endif

  // Latch controls, priority: memory wait, branch flush, RAW stall, fetch miss.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_sRST  = 1'b0;
    idex_en    = 1'b1;
    idex_sRST  = 1'b0;
    exmem_en   = 1'b1;
    exmem_sRST = 1'b0;
    memwb_en   = 1'b1;
    memwb_sRST = 1'b0;
    if (mem_wait) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_sRST = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_sRST = 1'b1;
      idex_sRST = 1'b1;
    end else if (raw_hit) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_sRST = 1'b1;
    end else if (!ihit) begin
      pc_en     = 1'b0;
      ifid_sRST = 1'b1;
    end
  end

  // Scoreboard: first three entries follow their pipeline latches, the rest shift.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < SB_DEPTH; k++) sb[k] <= '0;
    end else begin
      if (idex_sRST)       sb[0] <= '0;
      else if (idex_en)    sb[0] <= id_ent;
      if (exmem_sRST)      sb[1] <= '0;
      else if (exmem_en)   sb[1] <= sb[0];
      if (memwb_sRST)      sb[2] <= '0;
      else if (memwb_en)   sb[2] <= sb[1];
      for (int k = 3; k < SB_DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

`ifdef FORWARDING_EN
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  // Youngest producer wins: EX/MEM (entry 0) before MEM/WB (entry 1).
  always_comb begin
    fwd_a_nxt = m1[0] ? 2'd1 : (m1[1] ? 2'd2 : 2'd0);
    fwd_b_nxt = m2[0] ? 2'd1 : (m2[1] ? 2'd2 : 2'd0);
  end

  // Selects travel with the instruction into ID/EX; a bubble carries none.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fwd_a <= 2'd0;
      fwd_b <= 2'd0;
    end else if (idex_sRST) begin
      fwd_a <= 2'd0;
      fwd_b <= 2'd0;
    end else if (idex_en) begin
      fwd_a <= fwd_a_nxt;
      fwd_b <= fwd_b_nxt;
    end
  end
`else
  assign fwd_a = 2'd0;
  assign fwd_b = 2'd0;
`endif

  // Data-memory wait FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mem_wait) state_nxt = DWAIT;
      DWAIT:   if (dhit || !mem_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  // Consecutive-stall watchdog, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)               stall_cnt <= '0;
    else if (pc_en)          stall_cnt <= '0;
    else if (!stall_timeout) stall_cnt <= stall_cnt + STALL_W'(1);
  end

  assign stall_timeout = &stall_cnt;

  // Fields not consumed in every build configuration.
  logic unused_bits;
  assign unused_bits = ^{id_load, sb[SB_DEPTH-1], m1, m2};

endmodule
